// File: rtl/core_pkg.sv
// core_pkg: shared RV32I decode constants.
//   - Immediate format codes (IMM_*), driven by the decode classifier into imm_gen.
//   - RV32I major opcode constants.
//   - Instruction / data widths and the decode buffer entry type.
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;
    localparam int unsigned INSTR_W   = 32;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_U  = 3'b011,
        IMM_J  = 3'b100,
        IMM_C  = 3'b101,
        IMM_SH = 3'b110
    } imm_op_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [INSTR_W-1:0]   instruction;
        logic [CORE_XLEN-1:0] pc;
        imm_op_e              imm_op;
        logic [CORE_XLEN-1:0] imm;
        logic                 illegal;
    } id_entry_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
//   instruction_i : raw instruction word
//   imm_op_i      : immediate format (IMM_*)
//   imm_o         : immediate; SH (shamt) and C (CSR uimm) are zero-extended,
//                   all other formats are sign-extended from bit 31.
module imm_gen
    import core_pkg::*;
(
    input  logic [INSTR_W-1:0]   instruction_i,
    input  imm_op_e              imm_op_i,
    output logic [CORE_XLEN-1:0] imm_o
);

    logic [INSTR_W-1:0] ins;
    logic               unused_opcode;

    assign ins           = instruction_i;
    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^instruction_i[6:0];

    always_comb begin
        imm_o = '0;
        unique case (imm_op_i)
            IMM_I:   imm_o = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm_o = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_o = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm_o = {ins[31:12], 12'b0};
            IMM_J:   imm_o = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_C:   imm_o = {27'b0, ins[19:15]};
            IMM_SH:  imm_o = {27'b0, ins[24:20]};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: decode-stage controller between fetch and execute.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   flush_i               : drop every buffered instruction (redirect)
//   if_*                  : fetch side valid/ready handshake, instruction and PC
//   id_*, ex_ready_i      : execute side handshake and registered decode payload
// Each fetched instruction is classified into an immediate format, expanded by
// imm_gen and registered into a 2-entry skid buffer (main + skid). if_ready_o
// is a flop, so execute back-pressure never reaches fetch combinationally.
module decode_ctrl
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32  // only 32 is supported
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [31:0]        if_instruction_i,
    input  logic [XLEN-1:0]    if_pc_i,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    output logic               id_valid_o,
    input  logic               ex_ready_i,
    output logic [31:0]        id_instruction_o,
    output logic [XLEN-1:0]    id_pc_o,
    output logic [2:0]         id_imm_op_o,
    output logic [XLEN-1:0]    id_imm_o,
    output logic               id_illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    imm_op_e    imm_op;
    logic       illegal;
    logic [CORE_XLEN-1:0] imm;

    id_entry_t new_entry, main_q, skid_q;
    logic      main_valid_q, skid_valid_q, ready_q;
    logic      main_valid_d, skid_valid_d;
    logic      accept, consume;
    logic      load_main_new, load_main_skid, load_skid;

    assign opcode = if_instruction_i[6:0];
    assign funct3 = if_instruction_i[14:12];

    always_comb begin
        imm_op  = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR:  imm_op = IMM_I;
            OPC_OP_IMM:          imm_op = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
            OPC_STORE:           imm_op = IMM_S;
            OPC_BRANCH:          imm_op = IMM_B;
            OPC_LUI, OPC_AUIPC:  imm_op = IMM_U;
            OPC_JAL:             imm_op = IMM_J;
            // CSR immediate forms (csrrwi/csrrsi/csrrci) carry a 5-bit uimm.
            OPC_SYSTEM:          imm_op = (funct3 >= 3'b101) ? IMM_C : IMM_I;
            OPC_OP, OPC_MISC_MEM: imm_op = IMM_I;
            default:             illegal = 1'b1;
        endcase
    end

    imm_gen u_imm_gen (
        .instruction_i (if_instruction_i),
        .imm_op_i      (imm_op),
        .imm_o         (imm)
    );

    assign new_entry = '{instruction: if_instruction_i, pc: if_pc_i, imm_op: imm_op,
                         imm: imm, illegal: illegal};

    assign accept  = if_valid_i & ready_q;
    assign consume = main_valid_q & ex_ready_i;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume && skid_valid_q) begin
            // Skid advances into main; a same-cycle accept refills skid behind it.
            main_valid_d   = 1'b1;
            load_main_skid = 1'b1;
            skid_valid_d   = accept;
            load_skid      = accept;
        end else if (!main_valid_q || consume) begin
            main_valid_d  = accept;
            load_main_new = accept;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            load_skid    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            if (load_main_skid) begin
                main_q <= skid_q;
            end else if (load_main_new) begin
                main_q <= new_entry;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign if_ready_o       = ready_q;
    assign id_valid_o       = main_valid_q;
    assign id_instruction_o = main_q.instruction;
    assign id_pc_o          = main_q.pc;
    assign id_imm_op_o      = main_q.imm_op;
    assign id_imm_o         = main_q.imm;
    assign id_illegal_o     = main_q.illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: the driver side pushes the hand-computed
// expected entry for every accepted instruction; an independent monitor pops
// and compares whenever the DUT presents id_valid_o.
module tb_decode_ctrl;

    localparam int NV = 17;

    typedef struct {
        logic [31:0] instr, pc, imm;
        logic [2:0]  op;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, if_valid_i, ex_ready_i;
    logic [31:0] if_instruction_i, if_pc_i;
    logic        if_ready_o, id_valid_o, id_illegal_o;
    logic [31:0] id_instruction_o, id_pc_o, id_imm_o;
    logic [2:0]  id_imm_op_o;

    logic [31:0] v_instr [NV];
    logic [31:0] v_imm   [NV];
    logic [2:0]  v_op    [NV];
    logic        v_ill   [NV];

    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    decode_ctrl #(.XLEN(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .if_instruction_i (if_instruction_i),
        .if_pc_i          (if_pc_i),
        .if_valid_i       (if_valid_i),
        .if_ready_o       (if_ready_o),
        .id_valid_o       (id_valid_o),
        .ex_ready_i       (ex_ready_i),
        .id_instruction_o (id_instruction_o),
        .id_pc_o          (id_pc_o),
        .id_imm_op_o      (id_imm_op_o),
        .id_imm_o         (id_imm_o),
        .id_illegal_o     (id_illegal_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push side: model occupancy checks, then record what the next edge accepts.
    always @(negedge clk) begin
        if (rst_i) begin
            sb.delete();
        end else begin
            chk("valid_vs_occupancy", {31'b0, id_valid_o}, {31'b0, sb.size() > 0});
            chk("ready_vs_occupancy", {31'b0, if_ready_o}, {31'b0, sb.size() < 2});
            if (flush_i) sb.delete();
            else if (if_valid_i && if_ready_o) sb.push_back(cur);
        end
    end

    // Monitor: compare presented entry against the scoreboard head.
    always begin
        @(negedge clk);
        #1;
        if (!rst_i && !flush_i && id_valid_o) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got instr 0x%08h expected none", id_instruction_o);
            end else begin
                chk("id_instruction", id_instruction_o, sb[0].instr);
                chk("id_pc", id_pc_o, sb[0].pc);
                chk("id_imm", id_imm_o, sb[0].imm);
                chk("id_imm_op", {29'b0, id_imm_op_o}, {29'b0, sb[0].op});
                chk("id_illegal", {31'b0, id_illegal_o}, {31'b0, sb[0].ill});
                if (ex_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input int idx, input logic [31:0] pc);
        if_valid_i       = 1'b1;
        if_instruction_i = v_instr[idx];
        if_pc_i          = pc;
        cur = '{v_instr[idx], pc, v_imm[idx], v_op[idx], v_ill[idx]};
    endtask

    // Offer a vector and hold it until accepted (bounded).
    task automatic send(input int idx, input logic [31:0] pc);
        logic acc;
        acc = 1'b0;
        drive(idx, pc);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = if_ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept of 0x%08h", v_instr[idx]);
        end
    endtask

    task automatic idle();
        if_valid_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_id_valid"}, {31'b0, id_valid_o}, 32'd0);
        chk({tag, "_if_ready"}, {31'b0, if_ready_o}, 32'd1);
        chk({tag, "_instr"}, id_instruction_o, 32'd0);
        chk({tag, "_pc"}, id_pc_o, 32'd0);
        chk({tag, "_imm"}, id_imm_o, 32'd0);
        chk({tag, "_imm_op"}, {29'b0, id_imm_op_o}, 32'd0);
        chk({tag, "_illegal"}, {31'b0, id_illegal_o}, 32'd0);
    endtask

    task automatic drain(input string tag);
        ex_ready_i = 1'b1;
        idle();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        chk(tag, sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        logic acc;
        // Hand-decoded expectations (format code, immediate, illegal).
        // beq 0xFE000EE3: imm[12]=1 imm[11]=bit7=1 imm[10:5]=111111 imm[4:1]=1110 -> -4.
        v_instr = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h123452B7, 32'h008000EF,
                    32'h01F09093, 32'h3401D073, 32'h0000007F, 32'h00812183, 32'h4051D193,
                    32'h002081B3, 32'h00000073, 32'hFFFFF117, 32'hFFC08067, 32'hABCDE05B,
                    32'h0FF0000F, 32'h3002E073};
        v_imm   = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008,
                    32'h0000001F, 32'h00000003, 32'h00000000, 32'h00000008, 32'h00000005,
                    32'h00000002, 32'h00000000, 32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFFFABC,
                    32'h000000FF, 32'h00000005};
        v_op    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd0, 3'd0, 3'd6,
                    3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd5};
        v_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held two edges with fetch offering.
        rst_i = 1'b1;
        flush_i = 1'b0;
        ex_ready_i = 1'b1;
        drive(0, 32'h1000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        send(0, 32'h1000);
        @(negedge clk);
        chk("first_after_reset_valid", {31'b0, id_valid_o}, 32'd1);
        @(posedge clk);
        #1;

        // Format sweep, back to back.
        c0 = cyc;
        for (int i = 0; i < 7; i++) send(i, 32'h2000 + 32'(i * 4));
        chk("sweep_back_to_back_cycles", 32'(cyc - c0), 32'd7);
        for (int i = 7; i < NV; i++) send(i, 32'h3000 + 32'(i * 4));
        drain("sweep_drain");

        // Back-pressure: A, B accepted, C held.
        ex_ready_i = 1'b0;
        send(1, 32'hA000);
        send(2, 32'hB000);
        @(negedge clk);
        chk("ready_low_after_B", {31'b0, if_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        drive(3, 32'hC000);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("C_held_ready", {31'b0, if_ready_o}, 32'd0);
            chk("stall_payload_A", id_instruction_o, v_instr[1]);
            @(posedge clk);
            #1;
        end
        ex_ready_i = 1'b1;
        send(3, 32'hC000);
        drain("backpressure_drain");

        // Flush with both entries full and fetch offering.
        ex_ready_i = 1'b0;
        send(0, 32'hD000);
        send(1, 32'hD004);
        drive(2, 32'hD008);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_full_valid", {31'b0, id_valid_o}, 32'd0);
        chk("flush_full_ready", {31'b0, if_ready_o}, 32'd1);
        ex_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Flush while an accept would otherwise land.
        ex_ready_i = 1'b0;
        send(4, 32'hE000);
        drive(5, 32'hE004);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_accept_valid", {31'b0, id_valid_o}, 32'd0);
        ex_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Flush and reset together, mid-operation.
        ex_ready_i = 1'b0;
        send(3, 32'hF000);
        send(4, 32'hF004);
        drive(5, 32'hF008);
        rst_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        flush_i = 1'b0;
        idle();
        check_reset_vals("flush_rst");
        ex_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Random handshake traffic over the directed vector table.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = if_valid_i && if_ready_o;
            @(posedge clk);
            #1;
            ex_ready_i = ($urandom_range(0, 9) < 6);
            flush_i = ($urandom_range(0, 299) == 0);
            if (!if_valid_i || acc) begin
                if ($urandom_range(0, 3) != 0) drive($urandom_range(0, NV - 1), $urandom);
                else idle();
            end
        end
        flush_i = 1'b0;
        drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
